bus_op_engine: RTL and testbench

- Sequential engine between the LLC controller and the system bus; carries out each bus operation requested by the controller.
- Accepts one request (operation, address) at a time, drives the address phase, waits out the snoop window and derives the snoop result.
- Runs the data phase for operations that move a line, then returns the snoop result to the controller over a valid/ready response channel.
- Bus operation and snoop result encodings are the shared bus package encodings.

---
 rtl/bus_op_engine.sv | 165 ++++++++++++++++
 tb/tb_bus_op_engine.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bus_op_engine.sv
// Bus operation engine: address phase, snoop window, data beats, then a response to the LLC controller.
// Optional BUS_TRACE_EN macro prints each snoop-result capture (simulation only).
module bus_op_engine #(
  parameter int SNOOP_LAT = 2,
  parameter int BEATS     = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_addr,
  output logic             bus_valid,
  output logic [2:0]       bus_op,
  output logic [31:0]      bus_addr,
  output logic             bus_beat_valid,
  output logic [3:0]       bus_beat_idx,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [1:0]       resp_snoop,
  output logic             resp_err,
  output logic [CNT_W-1:0] txn_count
);

  localparam logic [2:0] OP_READ  = 3'b001;
  localparam logic [2:0] OP_WRITE = 3'b010;
  localparam logic [2:0] OP_INV   = 3'b011;
  localparam logic [2:0] OP_RWIM  = 3'b100;

  localparam logic [1:0] SNP_NOHIT = 2'b00;
  localparam logic [1:0] SNP_HIT   = 2'b01;
  localparam logic [1:0] SNP_HITM  = 2'b10;

  localparam logic [3:0] SNP_LOAD  = 4'(SNOOP_LAT - 1);
  localparam logic [3:0] BEAT_LAST = 4'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_SNOOP,
    S_XFER,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      addr_q, addr_d;
  logic             err_q, err_d;
  logic [1:0]       snoop_q, snoop_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       beat_q, beat_d;
  logic [CNT_W-1:0] txn_q, txn_d;

  logic req_legal;
  logic [1:0] snoop_res;

  assign req_legal = (req_op == OP_READ) || (req_op == OP_WRITE) ||
                     (req_op == OP_INV)  || (req_op == OP_RWIM);

  // Snoop outcome is a pure function of the low address bits of the latched request.
  always_comb begin
    snoop_res = SNP_NOHIT;
    case (addr_q[1:0])
      2'b00:   snoop_res = SNP_HIT;
      2'b01:   snoop_res = SNP_HITM;
      default: snoop_res = SNP_NOHIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      snoop_q <= SNP_NOHIT;
      cnt_q   <= '0;
      beat_q  <= '0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      snoop_q <= snoop_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      txn_q   <= txn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    err_d   = err_q;
    snoop_d = snoop_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    txn_d   = txn_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          snoop_d = SNP_NOHIT;
          err_d   = !req_legal;
          state_d = req_legal ? S_ADDR : S_RESP;
        end
      end
      S_ADDR: begin
        cnt_d   = SNP_LOAD;
        state_d = S_SNOOP;
      end
      S_SNOOP: begin
        if (cnt_q == 4'd0) begin
          snoop_d = snoop_res;
          beat_d  = '0;
          state_d = (op_q == OP_INV) ? S_RESP : S_XFER;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_XFER: begin
        if (beat_q == BEAT_LAST) begin
          beat_d  = '0;
          state_d = S_RESP;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          txn_d   = txn_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus fields read as zero outside the address phase so idle bus lines stay quiet.
  assign req_ready      = (state_q == S_IDLE);
  assign bus_valid      = (state_q == S_ADDR);
  assign bus_op         = (state_q == S_ADDR) ? op_q : 3'b000;
  assign bus_addr       = (state_q == S_ADDR) ? addr_q : 32'h0;
  assign bus_beat_valid = (state_q == S_XFER);
  assign bus_beat_idx   = beat_q;
  assign resp_valid     = (state_q == S_RESP);
  assign resp_snoop     = snoop_q;
  assign resp_err       = err_q;
  assign txn_count      = txn_q;

`ifdef BUS_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst_n && state_q == S_SNOOP && cnt_q == 4'd0)
      $display("Busop: %0d, Address: %0h, Snoop Result: %0d", op_q, addr_q, snoop_res);
    if (rst_n && state_q == S_IDLE && req_valid && !req_legal)
      $display("Busop: %0d ILLEGAL", req_op);
  end
`else
`endif

endmodule

// File: tb/tb_bus_op_engine.sv
// Directed bench for bus_op_engine: reset, each op class, response back-pressure, back-to-back and counter wrap.
module tb_bus_op_engine;

  localparam logic [2:0] OP_READ  = 3'b001;
  localparam logic [2:0] OP_WRITE = 3'b010;
  localparam logic [2:0] OP_INV   = 3'b011;
  localparam logic [2:0] OP_RWIM  = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic        resp_ready = 1'b0;

  logic        req_ready, bus_valid, bus_beat_valid, resp_valid, resp_err;
  logic [2:0]  bus_op;
  logic [31:0] bus_addr;
  logic [3:0]  bus_beat_idx;
  logic [1:0]  resp_snoop;
  logic [15:0] txn_count;

  logic        req_ready4, bus_valid4, bus_beat_valid4, resp_valid4, resp_err4;
  logic [2:0]  bus_op4;
  logic [31:0] bus_addr4;
  logic [3:0]  bus_beat_idx4;
  logic [1:0]  resp_snoop4;
  logic [3:0]  txn_count4;

  int n_cmp = 0;
  int n_err = 0;
  int exp_txn = 0;

  always #5 clk = ~clk;

  bus_op_engine #(.SNOOP_LAT(2), .BEATS(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
    .bus_beat_valid(bus_beat_valid), .bus_beat_idx(bus_beat_idx),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_snoop(resp_snoop),
    .resp_err(resp_err), .txn_count(txn_count)
  );

  // Narrow-counter copy sharing all stimulus, used for the wrap check.
  bus_op_engine #(.SNOOP_LAT(2), .BEATS(8), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready4), .req_op(req_op), .req_addr(req_addr),
    .bus_valid(bus_valid4), .bus_op(bus_op4), .bus_addr(bus_addr4),
    .bus_beat_valid(bus_beat_valid4), .bus_beat_idx(bus_beat_idx4),
    .resp_valid(resp_valid4), .resp_ready(resp_ready), .resp_snoop(resp_snoop4),
    .resp_err(resp_err4), .txn_count(txn_count4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rst(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_bus_valid"}, bus_valid, 0);
    chk({tag, "_bus_op"}, bus_op, 0);
    chk({tag, "_bus_addr"}, bus_addr, 0);
    chk({tag, "_beat_valid"}, bus_beat_valid, 0);
    chk({tag, "_beat_idx"}, bus_beat_idx, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_snoop"}, resp_snoop, 0);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_txn"}, txn_count, 0);
    chk({tag, "_n_req_ready"}, req_ready4, 1);
    chk({tag, "_n_busy"}, {bus_valid4, bus_beat_valid4, resp_valid4, resp_err4}, 0);
    chk({tag, "_n_fields"}, {bus_op4, bus_beat_idx4, resp_snoop4, txn_count4}, 0);
    chk({tag, "_n_addr"}, bus_addr4, 0);
  endtask

  // One transaction from IDLE; lat counts edges from the accept edge to the first resp_valid cycle.
  task automatic run_txn(input logic [2:0] op, input logic [31:0] addr, input int beats,
                         input logic [1:0] snp, input logic err, input int lat, input int hold);
    int n, nb, nv;
    req_valid = 1'b1; req_op = op; req_addr = addr;
    cyc();
    req_valid = 1'b0; req_op = 3'b000; req_addr = 32'hFFFF_FFFF;
    n = 0; nb = 0; nv = 0;
    while (!resp_valid && n < 100) begin
      if (bus_valid) begin
        nv++;
        chk("bus_op", bus_op, op);
        chk("bus_addr", bus_addr, addr);
      end
      if (bus_beat_valid) begin
        chk("beat_idx", bus_beat_idx, nb);
        nb++;
      end
      chk("no_overlap", bus_valid & bus_beat_valid, 0);
      chk("busy_ready", req_ready, 0);
      cyc();
      n++;
    end
    chk("resp_latency", n, lat);
    chk("beat_count", nb, beats);
    chk("addr_phases", nv, err ? 0 : 1);
    chk("resp_snoop", resp_snoop, snp);
    chk("resp_err", resp_err, err);
    for (int k = 0; k < hold; k++) begin
      chk("hold_valid", resp_valid, 1);
      chk("hold_snoop", resp_snoop, snp);
      chk("hold_err", resp_err, err);
      chk("hold_ready", req_ready, 0);
      chk("hold_bus", bus_valid | bus_beat_valid, 0);
      cyc();
    end
    resp_ready = 1'b1;
    cyc();
    resp_ready = 1'b0;
    exp_txn++;
    chk("post_resp_valid", resp_valid, 0);
    chk("post_req_ready", req_ready, 1);
    chk("txn_count", txn_count, exp_txn);
    chk("txn_count4", txn_count4, exp_txn & 15);
  endtask

  initial begin
    int n, nb;
    #12;
    check_rst("rst0");
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    run_txn(OP_READ, 32'h0000_1000, 8, 2'b01, 1'b0, 11, 0);

    // Reset in the middle of a READ data phase, at beat 3.
    req_valid = 1'b1; req_op = OP_READ; req_addr = 32'h0000_1000;
    cyc();
    req_valid = 1'b0;
    repeat (6) cyc();
    chk("pre_rst_beat_valid", bus_beat_valid, 1);
    chk("pre_rst_beat_idx", bus_beat_idx, 3);
    rst_n = 1'b0;
    #1;
    check_rst("rst_mid");
    exp_txn = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_txn", txn_count, 0);

    run_txn(OP_RWIM, 32'h0000_2001, 8, 2'b10, 1'b0, 11, 0);
    run_txn(OP_INV,  32'h0000_3002, 0, 2'b00, 1'b0, 3, 0);
    run_txn(3'b111,  32'h0000_5000, 0, 2'b00, 1'b1, 0, 5);

    // Back-to-back WRITEs with req_valid held: one IDLE cycle between them.
    req_valid = 1'b1; req_op = OP_WRITE; req_addr = 32'h0000_4003; resp_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      cyc();
      chk("b2b_addr_phase", bus_valid, 1);
      nb = 0; n = 0;
      while (!resp_valid && n < 100) begin
        if (bus_beat_valid) nb++;
        cyc();
        n++;
      end
      chk("b2b_latency", n, 11);
      chk("b2b_beats", nb, 8);
      chk("b2b_snoop", resp_snoop, 0);
      cyc();
      exp_txn++;
      chk("b2b_idle_ready", req_ready, 1);
      chk("b2b_txn", txn_count, exp_txn);
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    cyc();

    // 16 more responses push the 4-bit counter through 15 -> 0.
    for (int i = 0; i < 16; i++)
      run_txn(OP_INV, 32'h0000_3002, 0, 2'b00, 1'b0, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
